// File: rtl/mem_arb_pkg.sv
// Shared types and address-legality rule for the unified-RAM port arbiter.
package mem_arb_pkg;

   typedef enum logic {IDLE, RD_WAIT} arb_state_t;
   typedef enum logic {REQ_IF, REQ_D} req_sel_t;

   localparam logic [31:0] MEM_BYTES_DEF  = 32'd16384;
   localparam logic [31:0] PROT_LIMIT_DEF = 32'h0000_0400;

   // Word-aligned, inside the RAM, and writes stay clear of the instruction region.
   function automatic logic addr_legal(
      input logic [31:0] addr,
      input logic        we,
      input logic [31:0] mem_bytes  = MEM_BYTES_DEF,
      input logic [31:0] prot_limit = PROT_LIMIT_DEF
   );
      return (addr[1:0] == 2'b00) && (addr <= mem_bytes - 32'd4) &&
             (!we || (addr >= prot_limit));
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Requester pick for the arbiter: D first, IF forced after MAX_STALL back-to-back D grants.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int MAX_STALL = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     arb_en,
   input  logic     if_req,
   input  logic     d_req,
   output logic     gnt_any,
   output req_sel_t sel
);

   localparam int CW = $clog2(MAX_STALL + 1);

   logic [CW-1:0] stall_cnt;

   always_comb begin
      gnt_any = arb_en && (if_req || d_req);
      sel     = REQ_D;
      if (if_req && (!d_req || (stall_cnt == CW'(MAX_STALL))))
         sel = REQ_IF;
   end

   // Counts D grants that IF sat through; any cycle without if_req forgives the debt.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (!if_req)
         stall_cnt <= '0;
      else if (gnt_any && (sel == REQ_IF))
         stall_cnt <= '0;
      else if (gnt_any && (stall_cnt != CW'(MAX_STALL)))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of the single-port unified RAM.
// Define MEM_ARB_PERF_CNT_EN to add the perf_if_wait / perf_d_wait stall counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter logic [31:0] MEM_BYTES  = MEM_BYTES_DEF,
   parameter logic [31:0] PROT_LIMIT = PROT_LIMIT_DEF,
   parameter int          RD_LAT     = 1,
   parameter int          MAX_STALL  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_fault,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_fault,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0] perf_if_wait,
   output logic [31:0] perf_d_wait,
`endif
   input  logic [31:0] mem_rdata
);

   arb_state_t  state;
   req_sel_t    owner;
   req_sel_t    sel;
   logic [2:0]  lat_cnt;
   logic        rd_ill;
   logic        gnt_any;
   logic        g_we;
   logic        g_legal;
   logic        rd_done;
   logic [31:0] g_addr;

   mem_arb_prio #(.MAX_STALL(MAX_STALL)) u_prio (
      .clk     (clk),
      .rst     (rst),
      .arb_en  (!rst && (state == IDLE)),
      .if_req  (if_req),
      .d_req   (d_req),
      .gnt_any (gnt_any),
      .sel     (sel)
   );

   assign g_we    = (sel == REQ_D) && d_we;
   assign g_addr  = (sel == REQ_D) ? d_addr : if_addr;
   assign g_legal = addr_legal(g_addr, g_we, MEM_BYTES, PROT_LIMIT);

   assign if_gnt    = gnt_any && (sel == REQ_IF);
   assign d_gnt     = gnt_any && (sel == REQ_D);
   assign mem_en    = gnt_any && g_legal;
   assign mem_we    = mem_en && g_we;
   assign mem_addr  = mem_en ? g_addr : '0;
   assign mem_wdata = mem_we ? d_wdata : '0;

   // Illegal reads still complete on schedule, just with zero data.
   assign rd_done   = !rst && (state == RD_WAIT) && (lat_cnt == 3'(RD_LAT));
   assign if_rvalid = rd_done && (owner == REQ_IF);
   assign d_rvalid  = rd_done && (owner == REQ_D);
   assign if_rdata  = (if_rvalid && !rd_ill) ? mem_rdata : '0;
   assign d_rdata   = (d_rvalid && !rd_ill) ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= REQ_IF;
         lat_cnt  <= '0;
         rd_ill   <= 1'b0;
         if_fault <= 1'b0;
         d_fault  <= 1'b0;
      end else begin
         if_fault <= if_gnt && !g_legal;
         d_fault  <= d_gnt && !g_legal;
         case (state)
            IDLE: begin
               if (gnt_any && !g_we) begin
                  state   <= RD_WAIT;
                  owner   <= sel;
                  rd_ill  <= !g_legal;
                  lat_cnt <= 3'd1;
               end
            end
            RD_WAIT: begin
               if (lat_cnt == 3'(RD_LAT)) begin
                  state   <= IDLE;
                  lat_cnt <= '0;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_wait <= '0;
         perf_d_wait  <= '0;
      end else begin
         if (if_req && !if_gnt && (perf_if_wait != '1))
            perf_if_wait <= perf_if_wait + 32'd1;
         if (d_req && !d_gnt && (perf_d_wait != '1))
            perf_d_wait <= perf_d_wait + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random + directed bench: a cycle-level reference model predicts grants and queues
// expected rvalid/fault events; a monitor pops and compares them as the DUT emits them.
module tb_mem_port_arbiter;

   localparam int          LAT  = 1;
   localparam int          MAXS = 4;
   localparam logic [31:0] MEMB = 32'd16384;
   localparam logic [31:0] PROT = 32'h400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        if_req, if_gnt, if_rvalid, if_fault;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_fault;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.MEM_BYTES(MEMB), .PROT_LIMIT(PROT), .RD_LAT(LAT), .MAX_STALL(MAXS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_fault(if_fault),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Second instance with a longer read latency for the reset-during-read case.
   logic        r3_rst, r3_if_gnt, r3_if_rvalid, r3_if_fault;
   logic [31:0] r3_if_rdata;
   logic        r3_d_req, r3_d_gnt, r3_d_rvalid, r3_d_fault;
   logic [31:0] r3_d_addr, r3_d_rdata;
   logic        r3_mem_en, r3_mem_we;
   logic [31:0] r3_mem_addr, r3_mem_wdata, r3_mem_rdata;

   mem_port_arbiter #(.MEM_BYTES(MEMB), .PROT_LIMIT(PROT), .RD_LAT(3), .MAX_STALL(MAXS)) dut3 (
      .clk(clk), .rst(r3_rst),
      .if_req(1'b0), .if_addr(32'h0), .if_gnt(r3_if_gnt), .if_rvalid(r3_if_rvalid),
      .if_rdata(r3_if_rdata), .if_fault(r3_if_fault),
      .d_req(r3_d_req), .d_we(1'b0), .d_addr(r3_d_addr), .d_wdata(32'h0), .d_gnt(r3_d_gnt),
      .d_rvalid(r3_d_rvalid), .d_rdata(r3_d_rdata), .d_fault(r3_d_fault),
      .mem_en(r3_mem_en), .mem_we(r3_mem_we), .mem_addr(r3_mem_addr), .mem_wdata(r3_mem_wdata),
      .mem_rdata(r3_mem_rdata)
   );

   // Environment RAM: garbage on the read bus unless a read was actually issued.
   logic [31:0] ram [0:4095];
   logic [31:0] rd_pipe [0:LAT-1];
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr[13:2]] <= mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[13:2]] : 32'hBAD0_BAD0;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   logic [31:0] r3_pipe [0:2];
   always @(posedge clk) begin
      r3_pipe[0] <= (r3_mem_en && !r3_mem_we) ? (r3_mem_addr ^ 32'h5A5A_0000) : 32'hBAD0_BAD0;
      r3_pipe[1] <= r3_pipe[0];
      r3_pipe[2] <= r3_pipe[1];
   end
   assign r3_mem_rdata = r3_pipe[2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int cyc; logic [31:0] data; } exp_t;
   exp_t        if_rq[$], d_rq[$];
   int          if_fq[$], d_fq[$];
   logic [31:0] ref_ram [0:4095];
   int          free_at = 0;
   int          stall   = 0;
   bit          model_on = 0;

   task automatic model_step();
      logic        e_if, e_d, we, legal;
      logic [31:0] a;
      exp_t        e;
      e_if = 0; e_d = 0;
      if (cyc >= free_at) begin
         if (d_req && (!if_req || stall < MAXS)) e_d = 1;
         else if (if_req) e_if = 1;
      end
      check("if_gnt", if_gnt, e_if);
      check("d_gnt", d_gnt, e_d);
      if (e_d && if_req) stall = (stall < MAXS) ? stall + 1 : MAXS;
      if (e_if || !if_req) stall = 0;
      if (e_if || e_d) begin
         we    = e_d && d_we;
         a     = e_d ? d_addr : if_addr;
         legal = (a % 4 == 0) && (a <= MEMB - 4) && (!we || a >= PROT);
         check("mem_en", mem_en, legal);
         if (legal) begin
            check("mem_we", mem_we, we);
            check("mem_addr", mem_addr, a);
            if (we) check("mem_wdata", mem_wdata, d_wdata);
         end else if (e_d) d_fq.push_back(cyc + 1);
         else if_fq.push_back(cyc + 1);
         if (we) begin
            if (legal) ref_ram[a[13:2]] = d_wdata;
            free_at = cyc + 1;
         end else begin
            e.cyc  = cyc + LAT;
            e.data = legal ? ref_ram[a[13:2]] : 32'h0;
            if (e_d) d_rq.push_back(e); else if_rq.push_back(e);
            free_at = cyc + LAT + 1;
         end
      end else begin
         check("mem_en idle", mem_en, 1'b0);
      end
   endtask

   always @(negedge clk) if (model_on && !rst) model_step();

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (model_on && !rst) begin
         logic ev;
         exp_t e;
         ev = (if_rq.size() > 0) && (if_rq[0].cyc == cyc);
         check("if_rvalid", if_rvalid, ev);
         if (ev) begin e = if_rq.pop_front(); check("if_rdata", if_rdata, e.data); end
         else check("if_rdata idle", if_rdata, 32'h0);
         ev = (d_rq.size() > 0) && (d_rq[0].cyc == cyc);
         check("d_rvalid", d_rvalid, ev);
         if (ev) begin e = d_rq.pop_front(); check("d_rdata", d_rdata, e.data); end
         else check("d_rdata idle", d_rdata, 32'h0);
         ev = (if_fq.size() > 0) && (if_fq[0] == cyc);
         check("if_fault", if_fault, ev);
         if (ev) void'(if_fq.pop_front());
         ev = (d_fq.size() > 0) && (d_fq[0] == cyc);
         check("d_fault", d_fault, ev);
         if (ev) void'(d_fq.pop_front());
      end
   end

   int glog[$];
   always @(negedge clk) if (if_gnt || d_gnt) glog.push_back(d_gnt ? 1 : 0);

   // ---------------- drivers ----------------
   task automatic gap(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
      int n = 0;
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
      do begin @(negedge clk); n++; end while (!d_gnt && n < 300);
      if (!d_gnt) check("d_gnt timeout", d_gnt, 1'b1);
      @(posedge clk); #1;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
   endtask

   task automatic do_if(input logic [31:0] a);
      int n = 0;
      if_req = 1; if_addr = a;
      do begin @(negedge clk); n++; end while (!if_gnt && n < 300);
      if (!if_gnt) check("if_gnt timeout", if_gnt, 1'b1);
      @(posedge clk); #1;
      if_req = 0; if_addr = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0: a = 32'h4000;
         1: a = 32'h3FFC;
         2: a = (32'h3F0 + 4 * $urandom_range(0, 7)) | 32'($urandom_range(1, 3));
         3: a = 4 * $urandom_range(0, 4095);
         4: a = 32'h100;
         default: a = 32'h3F0 + 4 * $urandom_range(0, 15);
      endcase
      return a;
   endfunction

   initial begin
      #400000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      r3_rst = 1; r3_d_req = 0; r3_d_addr = 0;
      for (int i = 0; i < 4096; i++) begin
         ram[i] = $urandom; ref_ram[i] = ram[i];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", |{if_gnt, if_rvalid, if_rdata, if_fault, d_gnt, d_rvalid, d_rdata,
                               d_fault, mem_en, mem_we, mem_addr, mem_wdata}, 1'b0);
      @(posedge clk); #1;
      rst = 0; model_on = 1;

      // Directed cases, all checked through the model.
      do_if(32'h0008);
      gap(1);
      do_d(1, 32'h0400, 32'hDEAD_BEEF);
      do_d(0, 32'h0400, 32'h0);
      do_d(1, 32'h0100, 32'h1234_5678);
      do_d(0, 32'h0100, 32'h0);
      do_d(0, 32'h4000, 32'h0);
      do_d(0, 32'h0402, 32'h0);
      do_if(32'h3FFC);
      do_if(32'h0002);
      gap(2);

      // Starvation: both held, D streaming writes.
      glog.delete();
      fork
         begin do_if(32'h0010); do_if(32'h0014); end
         for (int i = 0; i < 10; i++) do_d(1, 32'h500 + 4 * i, $urandom);
      join
      check("grant log length", (glog.size() >= 10), 1'b1);
      if (glog.size() >= 10)
         for (int i = 0; i < 10; i++) check("grant order", glog[i], (i % 5 == 4) ? 0 : 1);
      gap(2);

      fork
         for (int i = 0; i < 60; i++) begin gap($urandom_range(0, 3)); do_if(rand_addr()); end
         for (int j = 0; j < 80; j++) begin
            gap($urandom_range(0, 2)); do_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
         end
      join
      gap(8);
      check("if rvalid drained", if_rq.size(), 0);
      check("d rvalid drained", d_rq.size(), 0);
      check("faults drained", if_fq.size() + d_fq.size(), 0);

      // Reset during an in-flight read, RD_LAT=3.
      r3_rst = 0;
      r3_d_req = 1; r3_d_addr = 32'h800;
      @(negedge clk);
      check("r3 gnt", r3_d_gnt, 1'b1);
      check("r3 mem_en", r3_mem_en, 1'b1);
      @(posedge clk); #1;
      r3_d_req = 0; r3_d_addr = 0; r3_rst = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("r3 outputs zero", |{r3_if_gnt, r3_if_rvalid, r3_if_rdata, r3_if_fault, r3_d_gnt,
                 r3_d_rvalid, r3_d_rdata, r3_d_fault, r3_mem_en, r3_mem_we, r3_mem_addr,
                 r3_mem_wdata}, 1'b0);
         @(posedge clk); #1;
         r3_rst = 0;
      end
      r3_d_req = 1; r3_d_addr = 32'h804;
      @(negedge clk);
      check("r3 gnt after rst", r3_d_gnt, 1'b1);
      @(posedge clk); #1;
      r3_d_req = 0; r3_d_addr = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("r3 d_rvalid", r3_d_rvalid, (k == 3));
         if (k == 3) check("r3 d_rdata", r3_d_rdata, 32'h804 ^ 32'h5A5A_0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
